pill_count_bank: RTL and testbench
==================================

Name: pill_count_bank

Overview:
- Multi-channel successor to the single pill-count register in the dispenser FSM project.
- Holds CHANNELS independent WIDTH-bit pill counts. Each count can be loaded by the operator and decremented by dispense requests from the dispenser FSM.
- Every dispense request is checked against the stored count and answered with an ack or error pulse. Per-channel empty/low/error flags and a total-dispensed statistic are provided for the display and alarm logic.

Parameters:
- WIDTH, 8, bit width of each channel count, A and DispQty.
- CHANNELS, 4, number of pill channels; must be >= 2.
- LOW_THRESH, 5, Low asserts when count <= LOW_THRESH; must fit in WIDTH bits.
- TOT_WIDTH, 16, width of the TotalDispensed counter.
- CH_BITS (localparam), $clog2(CHANNELS), channel-index width.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Load  in  1  load request for this cycle.
- LoadCh  in  CH_BITS  channel to load.
- A  in  WIDTH  value to load.
- Dispense  in  1  dispense request for this cycle.
- DispCh  in  CH_BITS  channel to dispense from.
- DispQty  in  WIDTH  number of pills requested.
- ClearErr  in  1  clears all ErrSticky bits.
- NumPills  out  CHANNELS*WIDTH  flattened counts; channel i occupies bits [i*WIDTH +: WIDTH].
- Empty  out  CHANNELS  count == 0 for each channel.
- Low  out  CHANNELS  count <= LOW_THRESH for each channel.
- DispAck  out  1  one-cycle pulse: the previous request was granted.
- DispErr  out  1  one-cycle pulse: the previous request was rejected.
- ErrSticky  out  CHANNELS  per-channel sticky reject flag.
- TotalDispensed  out  TOT_WIDTH  saturating sum of all granted quantities.

Behaviour:
- Reset (synchronous, active-high) has highest priority. On reset:
  - All counts, DispAck, DispErr, ErrSticky and TotalDispensed go to 0.
  - Empty = all 1s; Low = all 1s.
  - Load, Dispense and ClearErr in the same cycle are ignored.
- Load: if LoadCh < CHANNELS, the count for LoadCh becomes A at the next edge. An out-of-range LoadCh is ignored silently.
- Dispense decision, evaluated with pre-edge values:
  - Grant when DispCh < CHANNELS, the count >= DispQty, and the same channel is not being loaded this cycle.
  - Grant result: count -= DispQty; DispAck = 1 for exactly the following cycle; TotalDispensed += DispQty, clamped at 2^TOT_WIDTH-1 with no wrap.
  - Anything else is a reject: count unchanged; DispErr = 1 for the following cycle; ErrSticky[DispCh] set if DispCh is in range.
- Latency: one cycle from request to NumPills update and DispAck/DispErr. Back-to-back requests on consecutive cycles are each evaluated against the count already updated by the previous cycle.
- Boundary cases:
  - DispQty = 0: grant; count unchanged; ack pulse; total unchanged.
  - DispQty == count: grant; count reaches 0; Empty and Low assert the same cycle NumPills updates.
  - Load and Dispense on the same channel: Load wins, dispense is rejected (DispErr, sticky set).
  - Load and Dispense on different channels: both take effect in the same cycle.
  - No underflow is possible: a count never wraps below 0.
  - ClearErr together with a reject in the same cycle: the set wins for that channel's bit; all other bits clear.
  - Reset during any activity: state returns to the reset values above at the next edge; any pending pulse is dropped.
- Empty and Low are combinational decodes of the registered counts (no extra latency). DispAck and DispErr are registered and never high together.
- Dispense handling is a two-state per-request FSM: IDLE, then RESP (one pulse cycle), then IDLE. A new request arriving during RESP is accepted, which keeps one request per cycle as the throughput.

Decomposition:
- Shared package pill_pkg holds:
  - default WIDTH and CHANNELS;
  - the LOW_THRESH default;
  - the channel-index function/type;
  - the DispAck/DispErr response encoding, used by the dispenser FSM.
- One natural sub-module, pill_channel: a single counter with load, conditional subtract, empty/low decode and sticky error. pill_count_bank instantiates it CHANNELS times with a generate loop and adds:
  - channel decode;
  - grant logic;
  - response pulse registers;
  - the TotalDispensed saturating counter.

Test Plan:
- Reset, then Load ch2 with A=20, then Dispense ch2 qty 7 -> count 13; DispAck one cycle; TotalDispensed=7; Low[2]=0.
- Ch2=13; Dispense qty 14 -> count stays 13; DispErr pulse; ErrSticky[2]=1. Then ClearErr -> ErrSticky=0.
- Ch1=6; Dispense qty 1 -> count 5, Low[1]=1. Then Dispense qty 5 -> count 0, Empty[1]=1, DispAck.
- Same cycle: Load ch0 A=9, Dispense ch0 qty 1 -> ch0=9, DispErr. Same cycle: Load ch0 A=9, Dispense ch3 (count 4) qty 4 -> ch0=9, ch3=0, DispAck.
- With TOT_WIDTH=4: grant totals of 10 then 10 -> TotalDispensed=15 (saturated, no wrap).
- Assert Reset on the same cycle as a valid Dispense -> no DispAck next cycle; all counts 0; Empty all 1s.

Source files
------------

// File: rtl/pill_pkg.sv
// Shared definitions for the pill-count bank and the dispenser FSM that drives it.
// Latency: none (types, constants and a pure function only).
// Backpressure: none.
// Contents: default sizes, low threshold, channel-range helper, response encoding.
package pill_pkg;

   localparam int DEF_WIDTH      = 8;
   localparam int DEF_CHANNELS   = 4;
   localparam int DEF_LOW_THRESH = 5;

   // True when a channel index addresses an existing channel. Callers cast the
   // index to 32 bits so non-power-of-two channel counts are handled correctly.
   function automatic logic ch_in_range(input int unsigned ch, input int unsigned n);
      return ch < n;
   endfunction

   // Per-request handshake FSM states.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } disp_st_e;

   // Response encoding seen by the dispenser FSM as {DispErr, DispAck}.
   typedef enum logic [1:0] {
      RSP_NONE = 2'b00,
      RSP_ACK  = 2'b01,
      RSP_ERR  = 2'b10
   } disp_rsp_e;

endpackage

// File: rtl/pill_channel.sv
// One pill-count channel: loadable counter with guarded subtract, flag decode and sticky error.
// Latency: count and sticky update one cycle after the enables; empty/low follow count combinationally.
// Backpressure: none; the parent only asserts sub_en when the count covers sub_qty.
// Ports: Clk/Reset (sync, active-high); load_en/load_val; sub_en/sub_qty; err_set/err_clr;
//        count, empty, low, err_sticky outputs.
module pill_channel #(
   parameter int WIDTH      = pill_pkg::DEF_WIDTH,
   parameter int LOW_THRESH = pill_pkg::DEF_LOW_THRESH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             load_en,
   input  logic [WIDTH-1:0] load_val,
   input  logic             sub_en,
   input  logic [WIDTH-1:0] sub_qty,
   input  logic             err_set,
   input  logic             err_clr,
   output logic [WIDTH-1:0] count,
   output logic             empty,
   output logic             low,
   output logic             err_sticky
);

   localparam logic [WIDTH-1:0] LOW_T = WIDTH'(LOW_THRESH);

   logic [WIDTH-1:0] count_d, count_q;
   logic             err_d, err_q;

   always_comb begin
      count_d = count_q;
      if (load_en) begin
         count_d = load_val;
      end else if (sub_en) begin
         count_d = count_q - sub_qty;
      end
      // A reject in the same cycle as a clear keeps the bit set.
      err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign count      = count_q;
   assign empty      = (count_q == '0);
   assign low        = (count_q <= LOW_T);
   assign err_sticky = err_q;

endmodule

// File: rtl/pill_count_bank.sv
// Bank of CHANNELS pill counters with operator load, checked dispense and a saturating total.
// Latency: one cycle from request to NumPills update and the DispAck/DispErr pulse.
// Backpressure: none; one request per cycle is always accepted, including during a response pulse.
// Ports: Clk/Reset (sync, active-high); Load/LoadCh/A; Dispense/DispCh/DispQty; ClearErr;
//        NumPills (flattened), Empty, Low, DispAck, DispErr, ErrSticky, TotalDispensed.
module pill_count_bank
   import pill_pkg::*;
#(
   parameter  int WIDTH      = DEF_WIDTH,
   parameter  int CHANNELS   = DEF_CHANNELS,
   parameter  int LOW_THRESH = DEF_LOW_THRESH,
   parameter  int TOT_WIDTH  = 16,
   localparam int CH_BITS    = $clog2(CHANNELS)
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      Load,
   input  logic [CH_BITS-1:0]        LoadCh,
   input  logic [WIDTH-1:0]          A,
   input  logic                      Dispense,
   input  logic [CH_BITS-1:0]        DispCh,
   input  logic [WIDTH-1:0]          DispQty,
   input  logic                      ClearErr,
   output logic [CHANNELS*WIDTH-1:0] NumPills,
   output logic [CHANNELS-1:0]       Empty,
   output logic [CHANNELS-1:0]       Low,
   output logic                      DispAck,
   output logic                      DispErr,
   output logic [CHANNELS-1:0]       ErrSticky,
   output logic [TOT_WIDTH-1:0]      TotalDispensed
);

   // Sum is wide enough for either operand plus carry, so overflow is detectable.
   localparam int                 SUM_W   = ((TOT_WIDTH > WIDTH) ? TOT_WIDTH : WIDTH) + 1;
   localparam logic [SUM_W-1:0]   TOT_MAX = SUM_W'({TOT_WIDTH{1'b1}});

   logic [WIDTH-1:0]    cnt [CHANNELS];
   logic [CHANNELS-1:0] ld_en, sub_en, err_set;
   logic [WIDTH-1:0]    sel_cnt;
   logic                load_ok, disp_ok, grant;
   logic [SUM_W-1:0]    sum;

   disp_st_e             state_d, state_q;
   disp_rsp_e            rsp_d, rsp_q;
   logic [TOT_WIDTH-1:0] tot_d, tot_q;

   // Channel decode and grant, all on pre-edge counts.
   always_comb begin
      load_ok = Load && ch_in_range(32'(LoadCh), CHANNELS);
      disp_ok = ch_in_range(32'(DispCh), CHANNELS);
      sel_cnt = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (32'(DispCh) == i) sel_cnt = cnt[i];
      end
      // A load to the same channel takes precedence and forces a reject.
      grant = Dispense && disp_ok && (sel_cnt >= DispQty) &&
              !(load_ok && (LoadCh == DispCh));
      ld_en   = '0;
      sub_en  = '0;
      err_set = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         ld_en[i]   = load_ok && (32'(LoadCh) == i);
         sub_en[i]  = grant && (32'(DispCh) == i);
         err_set[i] = Dispense && !grant && (32'(DispCh) == i);
      end
   end

   // Response FSM and saturating total.
   always_comb begin
      state_d = Dispense ? ST_RESP : ST_IDLE;
      rsp_d   = !Dispense ? RSP_NONE : (grant ? RSP_ACK : RSP_ERR);
      sum     = SUM_W'(tot_q) + SUM_W'(DispQty);
      tot_d   = tot_q;
      if (grant) begin
         tot_d = (sum > TOT_MAX) ? '1 : sum[TOT_WIDTH-1:0];
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         rsp_q   <= RSP_NONE;
         tot_q   <= '0;
      end else begin
         state_q <= state_d;
         rsp_q   <= rsp_d;
         tot_q   <= tot_d;
      end
   end

   assign DispAck        = (state_q == ST_RESP) && (rsp_q == RSP_ACK);
   assign DispErr        = (state_q == ST_RESP) && (rsp_q == RSP_ERR);
   assign TotalDispensed = tot_q;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      pill_channel #(
         .WIDTH      (WIDTH),
         .LOW_THRESH (LOW_THRESH)
      ) u_ch (
         .Clk        (Clk),
         .Reset      (Reset),
         .load_en    (ld_en[g]),
         .load_val   (A),
         .sub_en     (sub_en[g]),
         .sub_qty    (DispQty),
         .err_set    (err_set[g]),
         .err_clr    (ClearErr),
         .count      (cnt[g]),
         .empty      (Empty[g]),
         .low        (Low[g]),
         .err_sticky (ErrSticky[g])
      );
      assign NumPills[g*WIDTH +: WIDTH] = cnt[g];
   end

endmodule

// File: tb/tb_pill_count_bank.sv
// Directed-vector bench for pill_count_bank with a queue-based scoreboard.
// Each applied vector carries hand-computed post-edge state; a monitor pops and checks it.
// TotalDispensed is 4 bits here so saturation is reachable with small quantities.
module tb_pill_count_bank;

   logic        Clk = 1'b0;
   logic        Reset, Load, Dispense, ClearErr;
   logic [1:0]  LoadCh, DispCh;
   logic [7:0]  A, DispQty;
   logic [31:0] NumPills;
   logic [3:0]  Empty, Low, ErrSticky;
   logic        DispAck, DispErr;
   logic [3:0]  TotalDispensed;

   always #5 Clk = ~Clk;

   pill_count_bank #(
      .WIDTH(8), .CHANNELS(4), .LOW_THRESH(5), .TOT_WIDTH(4)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Load(Load), .LoadCh(LoadCh), .A(A),
      .Dispense(Dispense), .DispCh(DispCh), .DispQty(DispQty), .ClearErr(ClearErr),
      .NumPills(NumPills), .Empty(Empty), .Low(Low), .DispAck(DispAck),
      .DispErr(DispErr), .ErrSticky(ErrSticky), .TotalDispensed(TotalDispensed)
   );

   typedef struct {
      logic       rst, ld;
      logic [1:0] lch;
      logic [7:0] a;
      logic       ds;
      logic [1:0] dch;
      logic [7:0] qty;
      logic       clr;
      logic [1:0] rsp;   // expected {DispErr, DispAck}
      logic [31:0] np;   // expected counts {ch3,ch2,ch1,ch0}
      logic [3:0] st;    // expected ErrSticky
      logic [3:0] tot;   // expected TotalDispensed
   } vec_t;

   vec_t vecs[$];
   int   exp_q[$];
   int   total = 0;
   int   bad   = 0;

   function automatic vec_t mk(input logic rst, input logic ld, input logic [1:0] lch,
                               input logic [7:0] a, input logic ds, input logic [1:0] dch,
                               input logic [7:0] qty, input logic clr, input logic [1:0] rsp,
                               input logic [31:0] np, input logic [3:0] st, input logic [3:0] tot);
      vec_t v;
      v.rst = rst; v.ld = ld; v.lch = lch; v.a = a; v.ds = ds; v.dch = dch;
      v.qty = qty; v.clr = clr; v.rsp = rsp; v.np = np; v.st = st; v.tot = tot;
      return v;
   endfunction

   function automatic logic [3:0] exp_empty(input logic [31:0] np);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (np[i*8 +: 8] == 8'd0);
      return r;
   endfunction

   function automatic logic [3:0] exp_low(input logic [31:0] np);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (np[i*8 +: 8] <= 8'd5);
      return r;
   endfunction

   task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s vec=%0d got=%h want=%h", nm, k, got, want);
      end
   endtask

   // Monitor: one expected record per consumed vector, checked mid-cycle.
   initial begin
      forever begin
         @(negedge Clk);
         if (exp_q.size() > 0) begin
            int   k;
            vec_t v;
            k = exp_q.pop_front();
            v = vecs[k];
            chk("rsp",      k, {30'd0, DispErr, DispAck}, {30'd0, v.rsp});
            chk("numpills", k, NumPills, v.np);
            chk("empty",    k, {28'd0, Empty}, {28'd0, exp_empty(v.np)});
            chk("low",      k, {28'd0, Low},   {28'd0, exp_low(v.np)});
            chk("sticky",   k, {28'd0, ErrSticky}, {28'd0, v.st});
            chk("total",    k, {28'd0, TotalDispensed}, {28'd0, v.tot});
         end
      end
   end

   initial begin
      Reset = 1'b0; Load = 1'b0; LoadCh = '0; A = '0;
      Dispense = 1'b0; DispCh = '0; DispQty = '0; ClearErr = 1'b0;

      //               rst ld lch a      ds dch qty     clr rsp    np              st       tot
      vecs.push_back(mk(1, 0, 0, 8'd0,   0, 0, 8'd0,   0, 2'b00, 32'h00_00_00_00, 4'b0000, 4'd0));  // 0 reset
      vecs.push_back(mk(0, 1, 2, 8'd20,  0, 0, 8'd0,   0, 2'b00, 32'h00_14_00_00, 4'b0000, 4'd0));  // 1 load ch2=20
      vecs.push_back(mk(0, 0, 0, 8'd0,   1, 2, 8'd7,   0, 2'b01, 32'h00_0D_00_00, 4'b0000, 4'd7));  // 2 grant 7
      vecs.push_back(mk(0, 0, 0, 8'd0,   1, 2, 8'd14,  0, 2'b10, 32'h00_0D_00_00, 4'b0100, 4'd7));  // 3 reject 14>13
      vecs.push_back(mk(0, 0, 0, 8'd0,   0, 0, 8'd0,   1, 2'b00, 32'h00_0D_00_00, 4'b0000, 4'd7));  // 4 clear
      vecs.push_back(mk(0, 1, 1, 8'd6,   0, 0, 8'd0,   0, 2'b00, 32'h00_0D_06_00, 4'b0000, 4'd7));  // 5 load ch1=6
      vecs.push_back(mk(0, 0, 0, 8'd0,   1, 1, 8'd1,   0, 2'b01, 32'h00_0D_05_00, 4'b0000, 4'd8));  // 6 ch1 -> 5 (low)
      vecs.push_back(mk(0, 0, 0, 8'd0,   1, 1, 8'd5,   0, 2'b01, 32'h00_0D_00_00, 4'b0000, 4'd13)); // 7 qty==count
      vecs.push_back(mk(0, 1, 3, 8'd4,   0, 0, 8'd0,   0, 2'b00, 32'h04_0D_00_00, 4'b0000, 4'd13)); // 8 load ch3=4
      vecs.push_back(mk(0, 1, 0, 8'd9,   1, 0, 8'd1,   0, 2'b10, 32'h04_0D_00_09, 4'b0001, 4'd13)); // 9 load wins same ch
      vecs.push_back(mk(0, 1, 0, 8'd9,   1, 3, 8'd4,   0, 2'b01, 32'h00_0D_00_09, 4'b0001, 4'd15)); // 10 diff ch, 17 clamps
      vecs.push_back(mk(0, 0, 0, 8'd0,   1, 1, 8'd0,   0, 2'b01, 32'h00_0D_00_09, 4'b0001, 4'd15)); // 11 qty 0 on empty
      vecs.push_back(mk(0, 0, 0, 8'd0,   1, 2, 8'd200, 1, 2'b10, 32'h00_0D_00_09, 4'b0100, 4'd15)); // 12 clear+reject
      vecs.push_back(mk(0, 0, 0, 8'd0,   1, 0, 8'd9,   0, 2'b01, 32'h00_0D_00_00, 4'b0100, 4'd15)); // 13 back-to-back
      vecs.push_back(mk(1, 1, 1, 8'd50,  1, 2, 8'd1,   1, 2'b00, 32'h00_00_00_00, 4'b0000, 4'd0));  // 14 reset wins
      vecs.push_back(mk(0, 1, 0, 8'd10,  0, 0, 8'd0,   0, 2'b00, 32'h00_00_00_0A, 4'b0000, 4'd0));  // 15
      vecs.push_back(mk(0, 1, 1, 8'd10,  0, 0, 8'd0,   0, 2'b00, 32'h00_00_0A_0A, 4'b0000, 4'd0));  // 16
      vecs.push_back(mk(0, 0, 0, 8'd0,   1, 0, 8'd10,  0, 2'b01, 32'h00_00_0A_00, 4'b0000, 4'd10)); // 17 total 10
      vecs.push_back(mk(0, 0, 0, 8'd0,   1, 1, 8'd10,  0, 2'b01, 32'h00_00_00_00, 4'b0000, 4'd15)); // 18 saturate, no wrap
      vecs.push_back(mk(0, 0, 0, 8'd0,   1, 1, 8'd1,   0, 2'b10, 32'h00_00_00_00, 4'b0010, 4'd15)); // 19 no underflow
      vecs.push_back(mk(0, 1, 3, 8'd200, 0, 0, 8'd0,   0, 2'b00, 32'hC8_00_00_00, 4'b0010, 4'd15)); // 20 load ch3=200
      vecs.push_back(mk(0, 0, 0, 8'd0,   0, 0, 8'd0,   0, 2'b00, 32'hC8_00_00_00, 4'b0010, 4'd15)); // 21 idle, no pulse
      vecs.push_back(mk(0, 0, 0, 8'd0,   1, 3, 8'd6,   0, 2'b01, 32'hC2_00_00_00, 4'b0010, 4'd15)); // 22 large count

      for (int k = 0; k < vecs.size(); k++) begin
         Reset    = vecs[k].rst;
         Load     = vecs[k].ld;
         LoadCh   = vecs[k].lch;
         A        = vecs[k].a;
         Dispense = vecs[k].ds;
         DispCh   = vecs[k].dch;
         DispQty  = vecs[k].qty;
         ClearErr = vecs[k].clr;
         @(posedge Clk);
         exp_q.push_back(k);
         #1;
      end
      Reset = 1'b0; Load = 1'b0; Dispense = 1'b0; ClearErr = 1'b0;

      repeat (3) @(negedge Clk);
      chk("drained", vecs.size(), exp_q.size(), 0);
      chk("quiet_pulse", vecs.size(), {30'd0, DispErr, DispAck}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
